// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM multicycle controller: FSM state codes,
// datapath select values and the per-state control bundle.
package arm_ctrl_pkg;

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] MULEX    = 4'd10;
    localparam logic [3:0] MULWB    = 4'd11;
    localparam logic [3:0] MULWB2   = 4'd12;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       ismul;
        logic       longflag;
    } ctrl_t;

    // MUL/UMULL/SMULL share the data-processing opcode space; MulBits tells them apart.
    function automatic logic is_mul(input logic [1:0] op, input logic [5:0] funct,
                                    input logic [3:0] mulbits);
        return (op == OP_DP) && (funct[5:4] == 2'b00) && (mulbits == 4'b1001);
    endfunction

endpackage

// File: rtl/mainfsm_outdec.sv
// Combinational Moore output decode: one control bundle per FSM state.
module mainfsm_outdec
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: default every field first so no path through the case leaves a latch.
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.irwrite   = 1'b1;
                ctrl.nextpc    = 1'b1;
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            MEMADR:   ctrl.alusrcb = SRCB_IMM;
            MEMREAD:  ctrl.adrsrc  = 1'b1;
            MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regw      = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adrsrc = 1'b1;
                ctrl.memw   = 1'b1;
            end
            EXECUTER: ctrl.aluop = 1'b1;
            EXECUTEI: begin
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = 1'b1;
            end
            ALUWB:    ctrl.regw = 1'b1;
            BRANCH: begin
                ctrl.alusrcb   = SRCB_IMM;
                ctrl.resultsrc = RES_ALURESULT;
                ctrl.branch    = 1'b1;
            end
            MULEX: begin
                ctrl.ismul = 1'b1;
                ctrl.aluop = 1'b1;
            end
            MULWB: begin
                ctrl.ismul = 1'b1;
                ctrl.regw  = 1'b1;
            end
            MULWB2: begin
                ctrl.ismul    = 1'b1;
                ctrl.longflag = 1'b1;
                ctrl.regw     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main controller: state register, next-state logic and the
// reset gating of the datapath write/commit enables.
module mainfsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] MulBits,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       isMul,
    output logic       longFlag
);

    logic [3:0] state, next_state;
    ctrl_t      dec, ctrl;

    always_ff @(posedge clk) begin
        // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (is_mul(Op, Funct, MulBits)) next_state = MULEX;
                else if (Op == OP_MEM)          next_state = MEMADR;
                else if (Op == OP_BR)           next_state = BRANCH;
                else if (Op == OP_DP)           next_state = Funct[5] ? EXECUTEI : EXECUTER;
                else                            next_state = FETCH;
            end
            MEMADR:   next_state = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            MULEX:    next_state = MULWB;
            MULWB:    next_state = (is_mul(Op, Funct, MulBits) && Funct[3]) ? MULWB2 : FETCH;
            default:  next_state = FETCH;
        endcase
    end

    mainfsm_outdec u_outdec (
        .state (state),
        .ctrl  (dec)
    );

    // Commit-type enables are masked the moment reset drops, even mid-store.
    always_comb begin
        ctrl = dec;
        if (!reset) begin
            ctrl.irwrite  = 1'b0;
            ctrl.nextpc   = 1'b0;
            ctrl.regw     = 1'b0;
            ctrl.memw     = 1'b0;
            ctrl.branch   = 1'b0;
            ctrl.longflag = 1'b0;
        end
    end

    assign IRWrite   = ctrl.irwrite;
    assign AdrSrc    = ctrl.adrsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ResultSrc = ctrl.resultsrc;
    assign NextPC    = ctrl.nextpc;
    assign RegW      = ctrl.regw;
    assign MemW      = ctrl.memw;
    assign Branch    = ctrl.branch;
    assign ALUOp     = ctrl.aluop;
    assign isMul     = ctrl.ismul;
    assign longFlag  = ctrl.longflag;

endmodule
